// File: rtl/tile_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tile_pkg (package) + layer-type define header
// Purpose : Shared layer-type encodings, controller state enum and the
//           illegal-configuration check used by tile_loop_ctrl and its users.
// Contents: `TILE_LT_* defines, LT_* localparams, state_e, cfg_illegal().
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
`ifndef TILE_DEFS_SVH
`define TILE_DEFS_SVH
`define TILE_LT_POINTWISE 2'd0
`define TILE_LT_DEPTHWISE 2'd1
`define TILE_LT_STANDARD  2'd2
`endif

package tile_pkg;

  localparam logic [1:0] LT_POINTWISE = `TILE_LT_POINTWISE;
  localparam logic [1:0] LT_DEPTHWISE = `TILE_LT_DEPTHWISE;
  localparam logic [1:0] LT_STANDARD  = `TILE_LT_STANDARD;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // zero_flags carries one bit per dimension that must be non-zero.
  function automatic logic cfg_illegal(input logic [1:0] lt,
                                       input logic [5:0] zero_flags);
    logic lt_ok;
    lt_ok = (lt == LT_POINTWISE) || (lt == LT_DEPTHWISE) || (lt == LT_STANDARD);
    return (|zero_flags) || !lt_ok;
  endfunction

endpackage

`default_nettype wire

// File: rtl/tile_edge_len.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tile_edge_len
// Purpose : Extent of a tile starting at base_i: min(tile_i, total_i-base_i).
//           The base+tile sum is formed one bit wider so it cannot wrap.
// Ports   : tile_i  - nominal tile size
//           total_i - loop extent
//           base_i  - tile origin
//           len_o   - clipped tile length (0 if base_i >= total_i)
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tile_edge_len #(
  parameter int W = 7
) (
  input  logic [W-1:0] tile_i,
  input  logic [W-1:0] total_i,
  input  logic [W-1:0] base_i,
  output logic [W-1:0] len_o
);

  logic [W:0] end_w;

  assign end_w = {1'b0, base_i} + {1'b0, tile_i};

  always_comb begin
    if (base_i >= total_i) begin
      len_o = '0;
    end else if (end_w > {1'b0, total_i}) begin
      len_o = total_i - base_i;
    end else begin
      len_o = tile_i;
    end
  end

endmodule

`default_nettype wire

// File: rtl/tile_loop_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tile_loop_ctrl
// Purpose : Walks a layer as a 3-deep tile loop (n outer, k middle, d inner)
//           and hands one registered descriptor per tile to the datapath with
//           a valid/ready handshake, waiting for tile_done between tiles.
// Ports   : clk, rst_n (sync, active-low)
//           start, layer_type, in_C, out_C, tile_D, tile_K, tile_n, num_n
//           tile_ready, tile_done           - datapath handshake
//           busy, tile_valid, d_base, k_base, d_len, k_len, n_base, n_len,
//           first_d, last_d, layer_done, cfg_err
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tile_loop_ctrl
  import tile_pkg::*;
#(
  parameter int DIM_W = 7,
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [1:0]       layer_type,
  input  logic [DIM_W-1:0] in_C,
  input  logic [DIM_W-1:0] out_C,
  input  logic [DIM_W-1:0] tile_D,
  input  logic [DIM_W-1:0] tile_K,
  input  logic [CNT_W-1:0] tile_n,
  input  logic [CNT_W-1:0] num_n,
  input  logic             tile_ready,
  input  logic             tile_done,
  output logic             busy,
  output logic             tile_valid,
  output logic [DIM_W-1:0] d_base,
  output logic [DIM_W-1:0] k_base,
  output logic [DIM_W-1:0] d_len,
  output logic [DIM_W-1:0] k_len,
  output logic [CNT_W-1:0] n_base,
  output logic [CNT_W-1:0] n_len,
  output logic             first_d,
  output logic             last_d,
  output logic             layer_done,
  output logic             cfg_err
);

  state_e state_q, state_d;

  // Latched layer configuration
  logic [1:0]       lt_q, lt_d;
  logic [DIM_W-1:0] in_c_q, in_c_d, out_c_q, out_c_d;
  logic [DIM_W-1:0] t_d_q, t_d_d, t_k_q, t_k_d;
  logic [CNT_W-1:0] t_n_q, t_n_d, num_n_q, num_n_d;

  // Loop counters; d_base_q and n_base_q double as descriptor outputs.
  // k_cnt_q is the real k counter, k_base_q is the presented value (which
  // mirrors d for depthwise layers).
  logic [DIM_W-1:0] d_base_q, d_base_d;
  logic [DIM_W-1:0] k_cnt_q, k_cnt_d;
  logic [CNT_W-1:0] n_base_q, n_base_d;

  // Registered descriptor fields
  logic [DIM_W-1:0] k_base_q, d_len_q, k_len_q;
  logic [CNT_W-1:0] n_len_q;
  logic             first_d_q, last_d_q;
  logic             cfg_err_q, cfg_err_d;
  logic             desc_load;

  // Next-descriptor values derived from next-state counters
  logic [DIM_W-1:0] d_len_nx, k_len_cnt_nx;
  logic [CNT_W-1:0] n_len_nx;
  logic [DIM_W-1:0] k_base_nx, k_len_nx;
  logic             first_nx, last_nx, is_dw_nx;

  // Loop-end detection on the tile currently presented
  logic is_dw_q, d_wrap, k_wrap, n_wrap;

  assign is_dw_q = (lt_q == LT_DEPTHWISE);
  assign d_wrap  = ({1'b0, d_base_q} + {1'b0, d_len_q}) >= {1'b0, in_c_q};
  assign k_wrap  = is_dw_q ||
                   (({1'b0, k_cnt_q} + {1'b0, k_len_q}) >= {1'b0, out_c_q});
  assign n_wrap  = ({1'b0, n_base_q} + {1'b0, n_len_q}) >= {1'b0, num_n_q};

  always_comb begin
    state_d   = state_q;
    lt_d      = lt_q;
    in_c_d    = in_c_q;
    out_c_d   = out_c_q;
    t_d_d     = t_d_q;
    t_k_d     = t_k_q;
    t_n_d     = t_n_q;
    num_n_d   = num_n_q;
    d_base_d  = d_base_q;
    k_cnt_d   = k_cnt_q;
    n_base_d  = n_base_q;
    cfg_err_d = 1'b0;
    desc_load = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (cfg_illegal(layer_type, {in_C == '0, out_C == '0, tile_D == '0,
                                       tile_K == '0, tile_n == '0, num_n == '0})) begin
            cfg_err_d = 1'b1;
          end else begin
            lt_d      = layer_type;
            in_c_d    = in_C;
            out_c_d   = out_C;
            t_d_d     = tile_D;
            t_k_d     = tile_K;
            t_n_d     = tile_n;
            num_n_d   = num_n;
            d_base_d  = '0;
            k_cnt_d   = '0;
            n_base_d  = '0;
            desc_load = 1'b1;
            state_d   = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (tile_ready) begin
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (tile_done) begin
          state_d   = ST_ISSUE;
          desc_load = 1'b1;
          if (!d_wrap) begin
            d_base_d = d_base_q + t_d_q;
          end else begin
            d_base_d = '0;
            if (!k_wrap) begin
              k_cnt_d = k_cnt_q + t_k_q;
            end else begin
              k_cnt_d = '0;
              if (n_wrap) begin
                // Final tile: leave the last descriptor on the outputs.
                state_d   = ST_DONE;
                desc_load = 1'b0;
              end else begin
                n_base_d = n_base_q + t_n_q;
              end
            end
          end
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  tile_edge_len #(.W(DIM_W)) u_len_d (
    .tile_i  (t_d_d),
    .total_i (in_c_d),
    .base_i  (d_base_d),
    .len_o   (d_len_nx)
  );

  tile_edge_len #(.W(DIM_W)) u_len_k (
    .tile_i  (t_k_d),
    .total_i (out_c_d),
    .base_i  (k_cnt_d),
    .len_o   (k_len_cnt_nx)
  );

  tile_edge_len #(.W(CNT_W)) u_len_n (
    .tile_i  (t_n_d),
    .total_i (num_n_d),
    .base_i  (n_base_d),
    .len_o   (n_len_nx)
  );

  // Depthwise collapses k onto d and marks every tile as a complete group.
  always_comb begin
    is_dw_nx  = (lt_d == LT_DEPTHWISE);
    k_base_nx = is_dw_nx ? d_base_d : k_cnt_d;
    k_len_nx  = is_dw_nx ? d_len_nx : k_len_cnt_nx;
    first_nx  = is_dw_nx || (d_base_d == '0);
    last_nx   = is_dw_nx ||
                (({1'b0, d_base_d} + {1'b0, d_len_nx}) == {1'b0, in_c_d});
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      lt_q      <= '0;
      in_c_q    <= '0;
      out_c_q   <= '0;
      t_d_q     <= '0;
      t_k_q     <= '0;
      t_n_q     <= '0;
      num_n_q   <= '0;
      d_base_q  <= '0;
      k_cnt_q   <= '0;
      n_base_q  <= '0;
      k_base_q  <= '0;
      d_len_q   <= '0;
      k_len_q   <= '0;
      n_len_q   <= '0;
      first_d_q <= 1'b0;
      last_d_q  <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      lt_q      <= lt_d;
      in_c_q    <= in_c_d;
      out_c_q   <= out_c_d;
      t_d_q     <= t_d_d;
      t_k_q     <= t_k_d;
      t_n_q     <= t_n_d;
      num_n_q   <= num_n_d;
      cfg_err_q <= cfg_err_d;
      if (desc_load) begin
        d_base_q  <= d_base_d;
        k_cnt_q   <= k_cnt_d;
        n_base_q  <= n_base_d;
        k_base_q  <= k_base_nx;
        d_len_q   <= d_len_nx;
        k_len_q   <= k_len_nx;
        n_len_q   <= n_len_nx;
        first_d_q <= first_nx;
        last_d_q  <= last_nx;
      end
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign tile_valid = (state_q == ST_ISSUE);
  assign layer_done = (state_q == ST_DONE);
  assign cfg_err    = cfg_err_q;
  assign d_base     = d_base_q;
  assign k_base     = k_base_q;
  assign d_len      = d_len_q;
  assign k_len      = k_len_q;
  assign n_base     = n_base_q;
  assign n_len      = n_len_q;
  assign first_d    = first_d_q;
  assign last_d     = last_d_q;

endmodule

`default_nettype wire

// File: doc/tile_loop_ctrl.md
TILE_LOOP_CTRL -- requirements
Module: tile_loop_ctrl

Interface
REQ-001 Parameters SHALL be:
  - DIM_W, 7, channel/tile width.
  - CNT_W, 32, spatial count width (matches tile_n).
REQ-002 Ports SHALL be, in this order:
  - clk  in  1  single clock, rising edge.
  - rst_n  in  1  reset, synchronous, active-low.
  - start  in  1  one-cycle layer start request.
  - layer_type  in  2  POINTWISE/DEPTHWISE/STANDARD encoding.
  - in_C, out_C  in  DIM_W  layer input/output channels.
  - tile_D, tile_K  in  DIM_W  channel tile sizes.
  - tile_n  in  CNT_W  spatial units per tile (GLB-fit result).
  - num_n  in  CNT_W  total spatial units in layer.
  - tile_ready  in  1  datapath accepts descriptor.
  - tile_done  in  1  one-cycle pulse, datapath finished current tile.
  - busy  out  1  layer in progress.
  - tile_valid  out  1  descriptor valid.
  - d_base, k_base  out  DIM_W  channel tile origins.
  - d_len, k_len  out  DIM_W  channel tile extents.
  - n_base, n_len  out  CNT_W  spatial tile origin and extent.
  - first_d, last_d  out  1  first/last input-channel tile of accumulation group.
  - layer_done  out  1  one-cycle completion pulse.
  - cfg_err  out  1  one-cycle illegal-config pulse.

Function
REQ-003 SHALL implement states IDLE, ISSUE, WAIT, DONE.
REQ-004 In IDLE, start with legal config SHALL latch all config inputs, zero all bases, and enter ISSUE next cycle.
REQ-005 Config SHALL be illegal if any of in_C, out_C, tile_D, tile_K, tile_n, num_n is zero, or layer_type is unencoded; illegal start SHALL pulse cfg_err one cycle and remain in IDLE.
REQ-006 start outside IDLE SHALL be ignored; latched config SHALL NOT change until return to IDLE.
REQ-007 In ISSUE, tile_valid SHALL be 1; descriptor SHALL be held stable until tile_ready; on tile_valid&&tile_ready, next state SHALL be WAIT.
REQ-008 In WAIT, tile_valid SHALL be 0; tile_done SHALL advance counters and go to DONE if the tile was last, else ISSUE.
REQ-009 tile_done outside WAIT SHALL be ignored.
REQ-010 Loop order SHALL be n outermost, k middle, d innermost.
REQ-011 d_base SHALL step by tile_D and wrap to 0 at in_C, carrying into k.
REQ-012 k_base SHALL step by tile_K and wrap to 0 at out_C, carrying into n.
REQ-013 n_base SHALL step by tile_n; the layer SHALL end when n_base+n_len >= num_n and both inner loops are at their last tile.
REQ-014 For DEPTHWISE, the k loop SHALL be collapsed: k_base=d_base and k_len=d_len; only d and n iterate; first_d=last_d=1.
REQ-015 Edge length SHALL be len = min(tile, total-base).
REQ-016 The base+tile comparison SHALL be computed one bit wider than its operands so that no wrap occurs.
REQ-017 first_d SHALL be 1 when d_base==0; last_d SHALL be 1 when d_base+d_len==in_C.
REQ-018 DONE SHALL assert layer_done for exactly one cycle, then go to IDLE.
REQ-019 busy SHALL be 1 in ISSUE, WAIT and DONE.
REQ-020 Descriptor outputs SHALL be registered.

Reset
REQ-021 On rst_n==0 at a clock edge, state SHALL become IDLE and all outputs and counters SHALL be 0, including mid-tile; the next start SHALL begin a fresh layer.

Structure
REQ-022 Layer-type encodings SHALL come from the shared define header.
REQ-023 The state enum and the illegal-config check SHALL live in shared package tile_pkg.
REQ-024 Sub-module tile_edge_len SHALL compute min(tile, total-base), parameterised on width, with one instance each for d, k and n.

Verification
REQ-025 POINTWISE, in_C=out_C=112, tile_D=tile_K=32, num_n=10, tile_n=4, immediate ready/done -> 48 descriptors; d_len sequence 32,32,32,16 per k; n_len 4,4,2; layer_done after 48th tile_done.
REQ-026 DEPTHWISE, in_C=out_C=112, tile_D=10, num_n=5, tile_n=5 -> 12 descriptors; k_base==d_base each time; last d_len=2; first_d=last_d=1 throughout.
REQ-027 tile_ready held low 5 cycles in ISSUE -> tile_valid held 1, descriptor bit-stable, no advance.
REQ-028 start with tile_n=0 -> cfg_err high exactly 1 cycle; busy stays 0; no tile_valid.
REQ-029 rst_n low one cycle during WAIT -> all outputs 0 next cycle; new start reproduces REQ-025 sequence from d_base=k_base=n_base=0.
REQ-030 start pulsed during ISSUE, and tile_done pulsed during ISSUE -> both ignored; descriptor sequence unchanged.
